fifo_2w_rr_arb: RTL and testbench

//  Round-robin arbiter that shares one dual-write-port FIFO (fifo_2w) among NUM_REQ producers.

---
 rtl/fifo_2w_rr_arb_if.sv | 27 ++
 rtl/fifo_2w_rr_arb.sv | 86 ++++++++
 tb/tb_fifo_2w_rr_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_2w_rr_arb_if.sv
// fifo_2w_rr_arb_if: producer request/ack bus plus the registered dual FIFO write ports
interface fifo_2w_rr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [CNT_WIDTH-1:0]          fifo_size;
    logic                          w_val_0;
    logic [DATA_WIDTH-1:0]         w_data_0;
    logic                          w_val_1;
    logic [DATA_WIDTH-1:0]         w_data_1;
    logic [IDX_WIDTH-1:0]          w_src_0;
    logic [IDX_WIDTH-1:0]          w_src_1;
    modport master (
        output req, req_data, fifo_size,
        input  ack, w_val_0, w_data_0, w_val_1, w_data_1, w_src_0, w_src_1
    );
    modport slave (
        input  req, req_data, fifo_size,
        output ack, w_val_0, w_data_0, w_val_1, w_data_1, w_src_0, w_src_1
    );
endinterface

// File: rtl/fifo_2w_rr_arb.sv
// fifo_2w_rr_arb: round-robin arbiter granting up to two producers per cycle into a dual-write FIFO
module fifo_2w_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input logic              clk,
    input logic              rst,
    input logic              enable,
    fifo_2w_rr_arb_if.slave  bus
);
    logic [IDX_WIDTH-1:0]  rr_ptr, g0, g1, nxt;
    logic                  f0, f1, grant0, grant1;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic [IDX_WIDTH:0]    pop;
    logic [1:0]            inflight, cap_free, cap_pop, slots;
    logic [CNT_WIDTH:0]    diff, free;

    assign inflight = {1'b0, bus.w_val_0} + {1'b0, bus.w_val_1};
    assign diff     = (CNT_WIDTH+1)'(FIFO_DEPTH - 1) - {1'b0, bus.fifo_size} - (CNT_WIDTH+1)'(inflight);
    assign free     = diff[CNT_WIDTH] ? '0 : diff;
    assign cap_free = (free >= (CNT_WIDTH+1)'(2)) ? 2'd2 : free[1:0];
    assign cap_pop  = (pop >= (IDX_WIDTH+1)'(2)) ? 2'd2 : pop[1:0];
    assign slots    = (rst || !enable) ? 2'd0 : (cap_free < cap_pop ? cap_free : cap_pop);
    assign grant0   = slots != 2'd0;
    assign grant1   = slots == 2'd2;
    assign nxt      = grant1 ? g1 : g0;

    // Pick first requester at/after rr_ptr, then the next one strictly after it, wrapping
    always_comb begin
        g0 = '0;
        g1 = '0;
        f0 = 1'b0;
        f1 = 1'b0;
        pop = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pop = pop + (IDX_WIDTH+1)'(bus.req[k]);
            if (!f0 && bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                f0 = 1'b1;
                g0 = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        for (int k = 1; k < NUM_REQ; k++) begin
            if (f0 && !f1 && bus.req[(int'(g0) + k) % NUM_REQ]) begin
                f1 = 1'b1;
                g1 = IDX_WIDTH'((int'(g0) + k) % NUM_REQ);
            end
        end
        d0 = bus.req_data[int'(g0)*DATA_WIDTH +: DATA_WIDTH];
        d1 = bus.req_data[int'(g1)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Acknowledge the granted requesters in the same cycle their data is captured
    always_comb begin
        bus.ack = '0;
        if (grant0) bus.ack[g0] = 1'b1;
        if (grant1) bus.ack[g1] = 1'b1;
    end

    // Register granted data onto the write ports and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.w_val_0  <= 1'b0;
            bus.w_val_1  <= 1'b0;
            bus.w_data_0 <= '0;
            bus.w_data_1 <= '0;
            bus.w_src_0  <= '0;
            bus.w_src_1  <= '0;
            rr_ptr       <= '0;
        end else begin
            bus.w_val_0 <= grant0;
            bus.w_val_1 <= grant1;
            if (grant0) begin
                bus.w_data_0 <= d0;
                bus.w_src_0  <= g0;
                rr_ptr       <= (nxt == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : nxt + IDX_WIDTH'(1);
            end
            if (grant1) begin
                bus.w_data_1 <= d1;
                bus.w_src_1  <= g1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_2w_rr_arb.sv
// tb_fifo_2w_rr_arb: directed vector table plus hand sequences for the round-robin FIFO arbiter
module tb_fifo_2w_rr_arb;
    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [3:0]  fs;
        logic [3:0]  ack;
        logic        v0;
        logic        v1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  s0;
        logic [1:0]  s1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tv[20];
    logic [3:0] acc;

    fifo_2w_rr_arb_if bus ();

    fifo_2w_rr_arb dut (.clk(clk), .rst(rst), .enable(enable), .bus(bus));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic [3:0] q, logic [3:0] f, logic [3:0] a,
                                logic v0, logic v1, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] s0, logic [1:0] s1);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.fs = f; v.ack = a;
        v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        tv[0]  = mk(1, 1, 4'hF, 0,  4'b0000, 0, 0, 32'h0,  32'h0,  0, 0);
        tv[1]  = mk(0, 1, 4'hF, 0,  4'b0011, 0, 0, 32'h0,  32'h0,  0, 0);
        tv[2]  = mk(0, 1, 4'hF, 0,  4'b1100, 1, 1, 32'hA0, 32'hA1, 0, 1);
        tv[3]  = mk(0, 1, 4'h0, 0,  4'b0000, 1, 1, 32'hA2, 32'hA3, 2, 3);
        tv[4]  = mk(0, 1, 4'h4, 0,  4'b0100, 0, 0, 32'hA2, 32'hA3, 2, 3);
        tv[5]  = mk(0, 1, 4'h9, 0,  4'b1001, 1, 0, 32'hA2, 32'hA3, 2, 3);
        tv[6]  = mk(0, 1, 4'hF, 0,  4'b0110, 1, 1, 32'hA3, 32'hA0, 3, 0);
        tv[7]  = mk(0, 1, 4'h0, 6,  4'b0000, 1, 1, 32'hA1, 32'hA2, 1, 2);
        tv[8]  = mk(0, 1, 4'hF, 6,  4'b1000, 0, 0, 32'hA1, 32'hA2, 1, 2);
        tv[9]  = mk(0, 1, 4'h0, 5,  4'b0000, 1, 0, 32'hA3, 32'hA2, 3, 2);
        tv[10] = mk(0, 1, 4'hF, 0,  4'b0011, 0, 0, 32'hA3, 32'hA2, 3, 2);
        tv[11] = mk(0, 1, 4'hF, 5,  4'b0000, 1, 1, 32'hA0, 32'hA1, 0, 1);
        tv[12] = mk(0, 1, 4'hF, 7,  4'b0000, 0, 0, 32'hA0, 32'hA1, 0, 1);
        tv[13] = mk(0, 1, 4'hF, 15, 4'b0000, 0, 0, 32'hA0, 32'hA1, 0, 1);
        tv[14] = mk(0, 0, 4'h6, 0,  4'b0000, 0, 0, 32'hA0, 32'hA1, 0, 1);
        tv[15] = mk(0, 0, 4'h6, 0,  4'b0000, 0, 0, 32'hA0, 32'hA1, 0, 1);
        tv[16] = mk(0, 1, 4'h6, 0,  4'b0110, 0, 0, 32'hA0, 32'hA1, 0, 1);
        tv[17] = mk(1, 1, 4'h6, 0,  4'b0000, 1, 1, 32'hA2, 32'hA1, 2, 1);
        tv[18] = mk(0, 1, 4'h0, 0,  4'b0000, 0, 0, 32'h0,  32'h0,  0, 0);
        tv[19] = mk(0, 1, 4'hF, 0,  4'b0011, 0, 0, 32'h0,  32'h0,  0, 0);
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'hA0 + i;
        rst = 1'b1;
        enable = 1'b1;
        bus.req = 4'hF;
        bus.fifo_size = '0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = tv[i].rst;
            enable = tv[i].en;
            bus.req = tv[i].req;
            bus.fifo_size = tv[i].fs;
            #2;
            chk($sformatf("r%0d ack", i), 32'(bus.ack), 32'(tv[i].ack));
            chk($sformatf("r%0d w_val_0", i), 32'(bus.w_val_0), 32'(tv[i].v0));
            chk($sformatf("r%0d w_val_1", i), 32'(bus.w_val_1), 32'(tv[i].v1));
            chk($sformatf("r%0d w_data_0", i), bus.w_data_0, tv[i].d0);
            chk($sformatf("r%0d w_data_1", i), bus.w_data_1, tv[i].d1);
            chk($sformatf("r%0d w_src_0", i), 32'(bus.w_src_0), 32'(tv[i].s0));
            chk($sformatf("r%0d w_src_1", i), 32'(bus.w_src_1), 32'(tv[i].s1));
        end
        // fifo_size stuck at 6: one write at a time, blocked while it is in flight
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.fifo_size = 4'd6;
        bus.req = 4'hF;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            chk($sformatf("lag c%0d ack", c), 32'(bus.ack), (c % 2 == 1) ? 32'h0 : (32'h1 << (c / 2)));
            if (c == 1) begin
                chk("lag w_val_0", 32'(bus.w_val_0), 32'h1);
                chk("lag w_val_1", 32'(bus.w_val_1), 32'h0);
                chk("lag w_data_0", bus.w_data_0, 32'hA0);
            end
        end
        // All four requesters served within two grant cycles, in round-robin FIFO order
        @(negedge clk);
        bus.fifo_size = '0;
        acc = '0;
        #2;
        chk("fair c0 ack", 32'(bus.ack), 32'b1001);
        acc = acc | bus.ack;
        @(negedge clk);
        #2;
        chk("fair c1 ack", 32'(bus.ack), 32'b0110);
        chk("fair c1 w_data_0", bus.w_data_0, 32'hA3);
        chk("fair c1 w_data_1", bus.w_data_1, 32'hA0);
        chk("fair overlap", 32'(acc & bus.ack), 32'h0);
        acc = acc | bus.ack;
        chk("fair coverage", 32'(acc), 32'hF);
        @(negedge clk);
        bus.req = '0;
        #2;
        chk("fair c2 w_data_0", bus.w_data_0, 32'hA1);
        chk("fair c2 w_data_1", bus.w_data_1, 32'hA2);
        chk("fair c2 ack", 32'(bus.ack), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
